// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared defaults, FSM state encoding and width helper for tdm_demux
package tdm_pkg;

    localparam int NCH_DEFAULT = 4;
    localparam int W_DEFAULT   = 8;

    localparam logic [0:0] STATE_HUNT = 1'b0;
    localparam logic [0:0] STATE_RUN  = 1'b1;

    // Never returns less than 1 so that counter vectors stay legal for tiny parameters.
    function automatic int tdm_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - serial-in / parallel-out bundle between frame source and tdm_demux
interface tdm_demux_if #(
    parameter int NCH = 4,
    parameter int W   = 8
) ();
    logic             in_valid;
    logic             in_bit;
    logic             in_sync;
    logic [NCH*W-1:0] out_data;
    logic             out_valid;
    logic             sync_err;

    modport master (
        output in_valid, in_bit, in_sync,
        input  out_data, out_valid, sync_err
    );

    modport slave (
        input  in_valid, in_bit, in_sync,
        output out_data, out_valid, sync_err
    );
endinterface

// File: rtl/tdm_chan_sr.sv
// rtl/tdm_chan_sr.sv - one channel's MSB-first W-bit shift register with shift enable
module tdm_chan_sr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en_i,
    input  logic         bit_i,
    output logic [W-1:0] sr_o
);
    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (shift_en_i) begin
            sr_d = {sr_q[W-2:0], bit_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_o = sr_q;
endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - bit-interleaved TDM demultiplexer; sync checking under TDM_DEMUX_SYNC_CHECK_EN
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int W   = W_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    tdm_demux_if.slave bus
);
    localparam int CW = tdm_clog2(NCH);
    localparam int BW = tdm_clog2(W);
    localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    ch_idx_q, ch_idx_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [NCH*W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             sync_err_q, sync_err_d;

    logic             take;
    logic             done;
    logic [CW-1:0]    eff_ch;
    logic [BW-1:0]    eff_bit;
    logic [NCH-1:0]   shift_en;
    logic [W-1:0]     sr [NCH];
    logic [NCH*W-1:0] frame_word;

    // A sync bit always restarts the frame, so it is placed as if counters were zero.
    always_comb begin
        take    = bus.in_valid && ((state_q == STATE_RUN) || bus.in_sync);
        eff_ch  = bus.in_sync ? '0 : ch_idx_q;
        eff_bit = bus.in_sync ? '0 : bit_cnt_q;
        done    = take && (eff_ch == CH_LAST) && (eff_bit == BIT_LAST);
    end

    always_comb begin
        shift_en = '0;
        for (int c = 0; c < NCH; c++) begin
            shift_en[c] = take && (eff_ch == CW'(c));
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        tdm_chan_sr #(.W(W)) u_sr (
            .clk       (clk),
            .rst_n     (rst_n),
            .shift_en_i(shift_en[c]),
            .bit_i     (bus.in_bit),
            .sr_o      (sr[c])
        );
    end

    // The last channel's register has not yet absorbed the final bit at completion.
    always_comb begin
        frame_word = '0;
        for (int c = 0; c < NCH - 1; c++) begin
            frame_word[W*c +: W] = sr[c];
        end
        frame_word[W*(NCH-1) +: W] = {sr[NCH-1][W-2:0], bus.in_bit};
    end

    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        bit_cnt_d   = bit_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        if (take) begin
            state_d = STATE_RUN;
            if (eff_ch == CH_LAST) begin
                ch_idx_d  = '0;
                bit_cnt_d = (eff_bit == BIT_LAST) ? '0 : eff_bit + BW'(1);
            end else begin
                ch_idx_d  = eff_ch + CW'(1);
                bit_cnt_d = eff_bit;
            end
        end
        if (done) begin
            out_data_d  = frame_word;
            out_valid_d = 1'b1;
        end
    end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    logic framed_q, framed_d;
    logic at_boundary;

    // framed_q remembers whether the frame now in progress was opened by a sync bit.
    always_comb begin
        at_boundary = (ch_idx_q == '0) && (bit_cnt_q == '0);
        sync_err_d  = bus.in_valid && (state_q == STATE_RUN) &&
                      ((bus.in_sync && !at_boundary) ||
                       (!bus.in_sync && at_boundary && framed_q));
        framed_d    = framed_q;
        if (take && (eff_ch == '0) && (eff_bit == '0)) begin
            framed_d = bus.in_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            framed_q <= 1'b0;
        end else begin
            framed_q <= framed_d;
        end
    end
`else
    assign sync_err_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STATE_HUNT;
            ch_idx_q    <= '0;
            bit_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_idx_q    <= ch_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sync_err  = sync_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - self-checking bench for tdm_demux with a frame-level reference model
module tb_tdm_demux;
    localparam int NCH = 4;
    localparam int W   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    tdm_demux_if #(.NCH(NCH), .W(W)) bus ();

    tdm_demux #(.NCH(NCH), .W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input logic s);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.in_sync  = s;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
    endtask

    // Expected frame result is simply the packed channel words; ordering comes from the stream rule.
    task automatic send_frame(input logic [31:0] word, input logic sync_first,
                              input int maxgap, input logic exp_err, output int last_cyc);
        int  g;
        logic first, last;
        last_cyc = 0;
        for (int k = W - 1; k >= 0; k--) begin
            for (int c = 0; c < NCH; c++) begin
                first = (k == W - 1) && (c == 0);
                last  = (k == 0) && (c == NCH - 1);
                drive_bit(word[W*c + k], sync_first && first);
                if (last) begin
                    chk("frame_valid", {63'd0, bus.out_valid}, 64'd1);
                    chk("frame_data", {32'd0, bus.out_data}, {32'd0, word});
                    last_cyc = cyc;
                end else begin
                    chk("early_valid", {63'd0, bus.out_valid}, 64'd0);
                end
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                if (first && sync_first) chk("sync_err", {63'd0, bus.sync_err}, {63'd0, exp_err});
`else
                chk("sync_err_tied", {63'd0, bus.sync_err}, {63'd0, exp_err & 1'b0});
`endif
                if (!last && maxgap > 0) begin
                    g = $urandom_range(maxgap, 0);
                    repeat (g) begin
                        @(posedge clk);
                        #1;
                        chk("gap_valid", {63'd0, bus.out_valid}, 64'd0);
                    end
                end
            end
        end
    endtask

    task automatic idle_check(input logic [31:0] hold);
        @(posedge clk);
        #1;
        chk("pulse_drop", {63'd0, bus.out_valid}, 64'd0);
        chk("data_hold", {32'd0, bus.out_data}, {32'd0, hold});
    endtask

    initial begin
        int t0, t1, tl;
        logic [31:0] w;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.in_sync  = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_data", {32'd0, bus.out_data}, 64'd0);
        chk("reset_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_err", {63'd0, bus.sync_err}, 64'd0);
        rst_n = 1'b1;

        send_frame(32'h00FF3CA5, 1'b1, 0, 1'b0, tl);
        idle_check(32'h00FF3CA5);

        send_frame(32'h00FF3CA5, 1'b1, 3, 1'b0, tl);
        idle_check(32'h00FF3CA5);

        send_frame(32'h04030201, 1'b1, 0, 1'b0, t0);
        send_frame(32'h40302010, 1'b0, 0, 1'b0, t1);
        chk("b2b_spacing", 64'(t1 - t0), 64'(NCH * W));
        idle_check(32'h40302010);

        for (int f = 0; f < 4; f++) begin
            w = $urandom;
            send_frame(w, (f == 0), 2, 1'b0, tl);
        end
        idle_check(w);

        drive_bit(1'b1, 1'b1);
        for (int i = 1; i < 12; i++) begin
            drive_bit(1'($urandom), 1'b0);
            chk("partial_valid", {63'd0, bus.out_valid}, 64'd0);
        end
        send_frame(32'h44332211, 1'b1, 0, 1'b1, tl);
        idle_check(32'h44332211);

        for (int i = 0; i < 9; i++) drive_bit(1'($urandom), (i == 0));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", {32'd0, bus.out_data}, 64'd0);
        chk("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            drive_bit(1'($urandom), 1'b0);
            chk("hunt_valid", {63'd0, bus.out_valid}, 64'd0);
            if (i == 19) chk("hunt_data", {32'd0, bus.out_data}, 64'd0);
        end
        chk("hunt_data_end", {32'd0, bus.out_data}, 64'd0);

        w = $urandom;
        send_frame(w, 1'b1, 1, 1'b0, tl);
        idle_check(w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Bit-interleaved time-division demultiplexer: separates one serial stream carrying NCH channels back into NCH parallel words. It is the receive-side counterpart of the channel multiplexers in our datapath library. A serial frame source feeds it, and it delivers one complete word per channel to downstream logic with a one-cycle valid pulse.

## Interface
- NCH, default 4: number of channels; must be a power of two and at least 2.
- W, default 8: bits per channel word.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit.
- in_sync  input  1  frame marker, qualified by in_valid; marks the bit as channel 0, bit MSB.
- out_data  output  NCH*W  channel c's word sits at out_data[W*c +: W].
- out_valid  output  1  one-cycle pulse: out_data was updated with a new frame.
- sync_err  output  1  one-cycle pulse on misaligned sync; only when TDM_DEMUX_SYNC_CHECK_EN is defined.

## Operation
- Stream order: for bit k = W-1 down to 0, send channel 0 bit k, then channel 1 bit k, up to channel NCH-1 bit k. One frame is NCH*W valid bits.
- States:
  - HUNT: after reset. Ignores all bits until in_valid && in_sync.
  - RUN: capturing a frame.
- Counters:
  - ch_idx is log2(NCH) bits.
  - bit_cnt is clog2(W) bits.
  - Both are 0 on entry to RUN.
- HUNT -> RUN on in_valid && in_sync. That bit is stored as channel 0 MSB, ch_idx becomes 1 and bit_cnt stays 0.
- In RUN, on each in_valid:
  - Shift in_bit into the shift register for ch_idx, MSB first: sr <= {sr[W-2:0], in_bit}.
  - ch_idx increments and wraps from NCH-1 to 0.
  - On that wrap, bit_cnt increments.
- Frame completion: when in_valid with ch_idx == NCH-1 and bit_cnt == W-1:
  - Load out_data from all shift registers, including the current bit.
  - Pulse out_valid.
  - Reset ch_idx and bit_cnt to 0 and stay in RUN (free-running, no sync needed).
- in_valid low: the counters and shift registers hold, and in_valid gaps of any length are allowed.
- Sync exactly at a frame boundary (RUN, ch_idx == 0, bit_cnt == 0): this is normal; no error.
- Sync mid-frame in RUN:
  - The partial frame is discarded.
  - The bit is taken as channel 0 MSB and the counters realign (ch_idx = 1, bit_cnt = 0).
  - out_data is not updated.
- out_data holds its value between frames.

## Timing
- Reset (asynchronous, immediate): out_data = 0, out_valid = 0, sync_err = 0, state = HUNT, counters = 0, shift registers = 0.
- Latency: the final frame bit is sampled at edge N. out_data and out_valid are visible after edge N; out_valid drops after edge N+1.
- Throughput: one bit per cycle; back-to-back frames give out_valid once every NCH*W valid cycles.
- All outputs are registered; there are no combinational input-to-output paths.
- rst_n asserted mid-frame: the partial frame is lost, the block returns to HUNT and out_data clears.

## Configuration
- TDM_DEMUX_SYNC_CHECK_EN defined:
  - sync_err pulses for one cycle, registered and aligned with the realigning edge, when a sync arrives in RUN at a non-boundary position.
  - sync_err also pulses when no sync accompanies the first bit of a frame whose previous frame was entered by sync.
- Not defined: sync_err is tied 0, and realignment behaviour is unchanged.

## Structure
- Package tdm_pkg holds:
  - default NCH and W;
  - the state encoding (HUNT = 1'b0, RUN = 1'b1);
  - the clog2 width helper.
- Sub-module tdm_chan_sr: one W-bit shift register with a shift enable, instantiated NCH times in a generate loop. The top level holds the FSM, the counters and the output register.

## Test plan
All scenarios use NCH=4, W=8.
- Reset mid-stream: drive rst_n low asynchronously between edges -> all outputs go to 0 immediately; the next frame is ignored until a sync.
- Basic frame: sync plus 32 bits encoding channel words A5, 3C, FF, 00 -> out_data = 32'h00FF3CA5 with a single out_valid pulse one edge after bit 32.
- Gapped input: the same frame with in_valid low for random 0-3 cycles between bits -> identical out_data, and out_valid fires exactly once.
- Back-to-back frames: two frames with sync only on the first (words 01,02,03,04 then 10,20,30,40) -> out_data = 32'h04030201, then 32'h40302010; the out_valid pulses are 32 cycles apart.
- Mid-frame sync: sync at bit 13 followed by a clean frame of words 11,22,33,44 -> no out_valid for the partial frame, then out_data = 32'h44332211. When TDM_DEMUX_SYNC_CHECK_EN is defined, sync_err = 1 for one cycle at the bit-13 edge.
- Bits before the first sync: 20 bits with in_sync = 0 after reset -> the block stays in HUNT, with out_valid = 0 and out_data = 0.
